// File: rtl/n1_pfetch_if.sv
// n1_pfetch_if: Wishbone-pipelined program bus, read-only view.
// master = fetch unit (cyc/stb/adr out), slave = program memory side.
interface n1_pfetch_if;
    logic        cyc;
    logic        stb;
    logic [15:0] adr;
    logic        stall;
    logic        ack;
    logic        rty;
    logic [15:0] dat;

    modport master (
        output cyc,
        output stb,
        output adr,
        input  stall,
        input  ack,
        input  rty,
        input  dat
    );

    modport slave (
        input  cyc,
        input  stb,
        input  adr,
        output stall,
        output ack,
        output rty,
        output dat
    );
endinterface

// File: rtl/n1_pfetch.sv
// n1_pfetch: N1 program fetch unit. Holds the PC, runs one pbus read
// per opcode and hands the opcode to the IR through valid/ready.
//
// Ports:
//   clk_i, async_rst_i      clock, async active-low reset
//   pagu2pf_*               change-of-flow target from the pagu
//   fc2pf_fetch_i / busy_o  fetch request from flow control
//   pbus                    Wishbone-pipelined program bus (master)
//   pf2ir_*, ir2pf_ready_i  opcode buffer handshake to the IR
//   pf2prs_pc_o             address of the buffered opcode
module n1_pfetch #(
    parameter logic [15:0] RESET_ADR = 16'h0000
) (
    input  logic        clk_i,
    input  logic        async_rst_i,

    input  logic        pagu2pf_adr_sel_i,
    input  logic [15:0] pagu2pf_radr_i,
    input  logic [15:0] pagu2pf_aadr_i,

    input  logic        fc2pf_fetch_i,
    output logic        pf2fc_busy_o,

    n1_pfetch_if.master pbus,

    output logic [15:0] pf2ir_opc_o,
    output logic        pf2ir_valid_o,
    input  logic        ir2pf_ready_i,

    output logic [15:0] pf2prs_pc_o
);

    typedef enum logic [2:0] {
        BOOT = 3'd0,
        IDLE = 3'd1,
        ADDR = 3'd2,
        DATA = 3'd3,
        HOLD = 3'd4
    } state_t;

    state_t      state_q;
    logic [15:0] pc_q;
    logic [15:0] opc_q;
    logic [15:0] pc_d;

    // Relative targets are taken from the current pc, which in HOLD is
    // the address of the opcode being consumed. Wraps modulo 2^16.
    always_comb begin
        pc_d = pc_q + pagu2pf_radr_i;
        if (pagu2pf_adr_sel_i) begin
            pc_d = pagu2pf_aadr_i;
        end
    end

    always_ff @(posedge clk_i or negedge async_rst_i) begin
        if (!async_rst_i) begin
            state_q <= BOOT;
            pc_q    <= RESET_ADR;
            opc_q   <= '0;
        end else begin
            unique case (state_q)
                BOOT: begin
                    state_q <= ADDR;
                end
                IDLE: begin
                    if (fc2pf_fetch_i) begin
                        pc_q    <= pc_d;
                        state_q <= ADDR;
                    end
                end
                ADDR: begin
                    if (!pbus.stall) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    // ack has priority over a simultaneous retry
                    if (pbus.ack) begin
                        opc_q   <= pbus.dat;
                        state_q <= HOLD;
                    end else if (pbus.rty) begin
                        state_q <= ADDR;
                    end
                end
                HOLD: begin
                    if (ir2pf_ready_i) begin
                        if (fc2pf_fetch_i) begin
                            pc_q    <= pc_d;
                            state_q <= ADDR;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= BOOT;
                end
            endcase
        end
    end

    // Outputs decode the state register only, so a bus-side input never
    // reaches an output combinationally and reset drops cyc/stb at once.
    assign pbus.cyc      = (state_q == ADDR) || (state_q == DATA);
    assign pbus.stb      = (state_q == ADDR);
    assign pbus.adr      = pc_q;
    assign pf2ir_valid_o = (state_q == HOLD);
    assign pf2ir_opc_o   = opc_q;
    assign pf2prs_pc_o   = pc_q;
    assign pf2fc_busy_o  = !((state_q == IDLE) ||
                             ((state_q == HOLD) && ir2pf_ready_i));

endmodule

// File: tb/tb_n1_pfetch.sv
// tb_n1_pfetch: scoreboard bench for the n1_pfetch program fetch unit.
// Expected {adr, opc} pairs are queued at fetch and checked at HOLD.
module tb_n1_pfetch;

    localparam logic [15:0] RST_ADR = 16'h0100;

    typedef struct packed {
        logic [15:0] adr;
        logic [15:0] opc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        adr_sel;
    logic [15:0] radr;
    logic [15:0] aadr;
    logic        fetch;
    logic        busy;
    logic [15:0] opc;
    logic        valid;
    logic        ready;
    logic [15:0] pc;

    n1_pfetch_if pbus ();

    n1_pfetch #(.RESET_ADR(RST_ADR)) dut (
        .clk_i             (clk),
        .async_rst_i       (rst_n),
        .pagu2pf_adr_sel_i (adr_sel),
        .pagu2pf_radr_i    (radr),
        .pagu2pf_aadr_i    (aadr),
        .fc2pf_fetch_i     (fetch),
        .pf2fc_busy_o      (busy),
        .pbus              (pbus),
        .pf2ir_opc_o       (opc),
        .pf2ir_valid_o     (valid),
        .ir2pf_ready_i     (ready),
        .pf2prs_pc_o       (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        exp_q[$];
    logic [15:0] model_pc;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bus responder for one transaction, entered while in ADDR.
    // Returns the number of edges from ADDR entry to HOLD.
    task automatic bus_xfer(input int stalls, input int rtys,
                            input bit both, output int n);
        int   s;
        int   r;
        exp_t e;
        s = stalls;
        r = rtys;
        n = 0;
        if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL sb_empty: got 0 entries want >0");
            return;
        end
        e = exp_q[0];
        for (int k = 0; k < 64; k++) begin
            n_cmp++;
            if (pbus.stb !== 1'b1 || pbus.cyc !== 1'b1 ||
                pbus.adr !== e.adr || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL addr_phase: got stb=%b cyc=%b adr=%h busy=%b want 1 1 %h 1",
                         pbus.stb, pbus.cyc, pbus.adr, busy, e.adr);
            end
            if (s > 0) begin
                pbus.stall = 1'b1;
                s--;
                tick();
                n++;
                continue;
            end
            pbus.stall = 1'b0;
            tick();
            n++;
            n_cmp++;
            if (pbus.cyc !== 1'b1 || pbus.stb !== 1'b0 || valid !== 1'b0) begin
                n_bad++;
                $display("FAIL data_phase: got cyc=%b stb=%b valid=%b want 1 0 0",
                         pbus.cyc, pbus.stb, valid);
            end
            if (r > 0) begin
                pbus.rty = 1'b1;
                tick();
                pbus.rty = 1'b0;
                n++;
                r--;
                continue;
            end
            pbus.ack = 1'b1;
            pbus.rty = both;
            pbus.dat = e.opc;
            tick();
            n++;
            pbus.ack = 1'b0;
            pbus.rty = 1'b0;
            pbus.dat = 16'hDEAD;
            e = exp_q.pop_front();
            n_cmp++;
            if (valid !== 1'b1 || opc !== e.opc || pc !== e.adr ||
                pbus.cyc !== 1'b0) begin
                n_bad++;
                $display("FAIL hold: got valid=%b opc=%h pc=%h cyc=%b want 1 %h %h 0",
                         valid, opc, pc, pbus.cyc, e.opc, e.adr);
            end
            return;
        end
        n_cmp++; n_bad++;
        $display("FAIL xfer_timeout: got no HOLD want HOLD");
    endtask

    // Consume the buffered opcode (or fetch from IDLE) and request a new one.
    task automatic fetch_req(input logic sel, input logic [15:0] r,
                             input logic [15:0] a, input logic [15:0] d);
        exp_t e;
        adr_sel = sel;
        radr    = r;
        aadr    = a;
        ready   = 1'b1;
        fetch   = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL accept_busy: got %b want 0", busy);
        end
        model_pc = sel ? a : 16'(model_pc + r);
        e.adr = model_pc;
        e.opc = d;
        exp_q.push_back(e);
        tick();
        fetch = 1'b0;
        ready = 1'b0;
        n_cmp++;
        if (valid !== 1'b0 || pbus.stb !== 1'b1 || pbus.adr !== model_pc) begin
            n_bad++;
            $display("FAIL accept: got valid=%b stb=%b adr=%h want 0 1 %h",
                     valid, pbus.stb, pbus.adr, model_pc);
        end
    endtask

    task automatic check_lat(input string nm, input int got, input int want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic test_reset();
        exp_t e;
        int   n;
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (pbus.cyc !== 1'b0 || pbus.stb !== 1'b0 || valid !== 1'b0 ||
            busy !== 1'b1 || pbus.adr !== RST_ADR || opc !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_state: got cyc=%b stb=%b valid=%b busy=%b adr=%h opc=%h",
                     pbus.cyc, pbus.stb, valid, busy, pbus.adr, opc);
        end
        rst_n = 1'b1;
        tick();
        model_pc = RST_ADR;
        e.adr = RST_ADR;
        e.opc = 16'hA5A5;
        exp_q.push_back(e);
        bus_xfer(0, 0, 1'b0, n);
        check_lat("boot_lat", n, 2);
    endtask

    task automatic test_rel_abs();
        int n;
        fetch_req(1'b0, 16'hFFFE, 16'h0000, 16'h1111);
        bus_xfer(0, 0, 1'b0, n);
        check_lat("rel_lat", n + 1, 3);
        fetch_req(1'b1, 16'h0000, 16'h3000, 16'h2222);
        bus_xfer(0, 0, 1'b0, n);
        fetch_req(1'b1, 16'h0000, 16'hFFFF, 16'h3333);
        bus_xfer(0, 0, 1'b0, n);
        fetch_req(1'b0, 16'h0001, 16'h0000, 16'h4444);
        bus_xfer(0, 0, 1'b0, n);
        fetch_req(1'b0, 16'hFFFF, 16'h0000, 16'h5555);
        bus_xfer(0, 0, 1'b0, n);
    endtask

    task automatic test_stall_retry();
        int n;
        fetch_req(1'b1, 16'h0000, 16'h1234, 16'hBEEF);
        // a fetch while busy must not move the pc
        fetch   = 1'b1;
        adr_sel = 1'b1;
        aadr    = 16'h7777;
        bus_xfer(3, 1, 1'b0, n);
        fetch = 1'b0;
        check_lat("stall_rty_lat", n + 1, 8);
    endtask

    task automatic test_backpressure();
        int n;
        logic [15:0] held;
        held  = opc;
        ready = 1'b0;
        fetch = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++;
            if (busy !== 1'b1 || pbus.stb !== 1'b0 || valid !== 1'b1 ||
                opc !== held || pc !== model_pc) begin
                n_bad++;
                $display("FAIL backpressure: got busy=%b stb=%b valid=%b opc=%h pc=%h",
                         busy, pbus.stb, valid, opc, pc);
            end
            tick();
        end
        fetch_req(1'b0, 16'h0010, 16'h0000, 16'h6A6A);
        bus_xfer(0, 0, 1'b0, n);
    endtask

    task automatic test_ack_rty();
        int n;
        fetch_req(1'b0, 16'h0001, 16'h0000, 16'h0F0F);
        bus_xfer(0, 0, 1'b1, n);
        check_lat("ack_rty_lat", n + 1, 3);
        // drain to IDLE; a stray ack there is ignored
        ready = 1'b1;
        tick();
        ready    = 1'b0;
        pbus.ack = 1'b1;
        pbus.dat = 16'h9999;
        tick();
        pbus.ack = 1'b0;
        n_cmp++;
        if (valid !== 1'b0 || pbus.cyc !== 1'b0 || busy !== 1'b0 ||
            opc !== 16'h0F0F) begin
            n_bad++;
            $display("FAIL idle_ack: got valid=%b cyc=%b busy=%b opc=%h want 0 0 0 0f0f",
                     valid, pbus.cyc, busy, opc);
        end
        fetch_req(1'b0, 16'h0002, 16'h0000, 16'h1357);
        bus_xfer(0, 0, 1'b0, n);
        check_lat("idle_lat", n + 1, 3);
    endtask

    task automatic test_back_to_back();
        int n;
        for (int i = 0; i < 4; i++) begin
            fetch_req(1'b0, 16'h0001, 16'h0000, 16'($urandom_range(0, 65535)));
            bus_xfer(0, 0, 1'b0, n);
            check_lat("b2b_lat", n + 1, 3);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   n;
        fetch_req(1'b1, 16'h0000, 16'h4000, 16'hAAAA);
        tick();
        n_cmp++;
        if (pbus.cyc !== 1'b1 || pbus.stb !== 1'b0) begin
            n_bad++;
            $display("FAIL pre_rst_data: got cyc=%b stb=%b want 1 0",
                     pbus.cyc, pbus.stb);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (pbus.cyc !== 1'b0 || pbus.stb !== 1'b0 || valid !== 1'b0 ||
            pbus.adr !== RST_ADR) begin
            n_bad++;
            $display("FAIL async_rst: got cyc=%b stb=%b valid=%b adr=%h want 0 0 0 %h",
                     pbus.cyc, pbus.stb, valid, pbus.adr, RST_ADR);
        end
        exp_q.delete();
        tick();
        // late ack across release and BOOT must be ignored
        pbus.ack = 1'b1;
        pbus.dat = 16'hEEEE;
        rst_n    = 1'b1;
        #1;
        n_cmp++;
        if (valid !== 1'b0 || pbus.stb !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL boot_state: got valid=%b stb=%b busy=%b want 0 0 1",
                     valid, pbus.stb, busy);
        end
        tick();
        pbus.ack = 1'b0;
        n_cmp++;
        if (valid !== 1'b0) begin
            n_bad++;
            $display("FAIL boot_ack: got valid=%b want 0", valid);
        end
        model_pc = RST_ADR;
        e.adr = RST_ADR;
        e.opc = 16'hC3C3;
        exp_q.push_back(e);
        bus_xfer(0, 0, 1'b0, n);
    endtask

    initial begin
        rst_n      = 1'b0;
        adr_sel    = 1'b0;
        radr       = 16'h0000;
        aadr       = 16'h0000;
        fetch      = 1'b0;
        ready      = 1'b0;
        pbus.stall = 1'b0;
        pbus.ack   = 1'b0;
        pbus.rty   = 1'b0;
        pbus.dat   = 16'h0000;
        model_pc   = RST_ADR;
        test_reset();
        test_rel_abs();
        test_stall_retry();
        test_backpressure();
        test_ack_rty();
        test_back_to_back();
        test_reset_mid();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_left: got %0d want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/n1_pfetch.md
# n1_pfetch

Program fetch unit of the N1 core, directly downstream of the program bus address generation unit (pagu). It consumes the pagu's absolute/relative change-of-flow addresses, holds the program counter, runs one Wishbone-pipelined read per opcode on the program bus, and hands each fetched opcode to the instruction register through a valid/ready handshake. It keeps at most one bus transaction outstanding and buffers exactly one opcode.

## Interface
- RESET_ADR, 16'h0000, address of the first opcode fetched after reset

- clk_i  in  1  system clock
- async_rst_i  in  1  asynchronous reset, active-low
- pagu2pf_adr_sel_i  in  1  1: absolute target, 0: relative target
- pagu2pf_radr_i  in  16  relative offset, two's complement (1 = sequential)
- pagu2pf_aadr_i  in  16  absolute target address
- fc2pf_fetch_i  in  1  fetch request; pagu inputs valid in the same cycle
- pf2fc_busy_o  out  1  fetch request cannot be accepted this cycle
- pbus_cyc_o  out  1  Wishbone cycle
- pbus_stb_o  out  1  Wishbone strobe
- pbus_adr_o  out  16  Wishbone address
- pbus_stall_i  in  1  Wishbone pipeline stall
- pbus_ack_i  in  1  Wishbone acknowledge
- pbus_rty_i  in  1  Wishbone retry
- pbus_dat_i  in  16  read data
- pf2ir_opc_o  out  16  buffered opcode
- pf2ir_valid_o  out  1  opcode buffer full
- ir2pf_ready_i  in  1  IR accepts opcode
- pf2prs_pc_o  out  16  address of the opcode in (or last placed in) the buffer

## Operation
- States: BOOT, IDLE, ADDR, DATA, HOLD. Reset state BOOT.
- Registers: pc (16), opc (16), state. pbus_adr_o = pc; pf2prs_pc_o = pc.
- Reset values: state=BOOT, pc=RESET_ADR, opc=0; hence cyc=stb=valid=0, busy=1, adr=RESET_ADR.
- BOOT: unconditional -> ADDR (boot fetch of RESET_ADR; pc unchanged).
- IDLE: busy=0. On fc2pf_fetch_i: pc <= target, -> ADDR.
- target = adr_sel ? aadr : pc + radr, 16-bit, wraps modulo 2^16 (pc=16'hFFFF, radr=1 -> 16'h0000; pc=0, radr=16'hFFFF -> 16'hFFFF).
- ADDR: cyc=1, stb=1. If !stall -> DATA, else stay.
- DATA: cyc=1, stb=0. ack: opc <= pbus_dat_i, -> HOLD. rty (no ack): -> ADDR, same pc (reissue). ack and rty together: ack wins. Neither: stay.
- HOLD: valid=1. If ready: valid drops next cycle; if fetch also asserted same cycle, pc <= target (computed from the pc of the consumed opcode) and -> ADDR; else -> IDLE. If !ready: stay, fetch ignored.
- busy = !(state==IDLE || (state==HOLD && ir2pf_ready_i)). fetch while busy is ignored; FC must hold it.
- cyc, stb, valid, busy are decoded from the state register only (busy also from ready); no path from pbus inputs to outputs.
- Ack/rty outside DATA are ignored. Asynchronous reset mid-transaction drops cyc/stb immediately; the in-flight transaction is abandoned and the boot fetch restarts.

## Timing
- Fetch accepted at edge N (IDLE, fetch=1): stb=1 during cycle N+1.
- No stall: DATA in N+2; ack in N+2 -> valid=1 in N+3. Minimum request-to-valid latency 3 cycles; each stall or retry cycle adds one.
- Back-to-back: HOLD with ready & fetch at cycle M -> stb=1 in M+1; sustained throughput one opcode per 3 cycles.
- pc changes only on edge of fetch acceptance; stable through ADDR/DATA/HOLD.
- After reset deassertion: BOOT for one cycle, stb=1 on the following cycle at RESET_ADR.

## Test plan
- Boot: RESET_ADR=16'h0100, release reset, ack with dat=16'hA5A5 first DATA cycle -> stb at adr 16'h0100 in cycle 2, valid=1 with opc=16'hA5A5, pf2prs_pc_o=16'h0100.
- Relative/absolute: from pc=16'h0100 consume opcode with fetch, adr_sel=0, radr=16'hFFFE -> adr 16'h00FE; next fetch adr_sel=1, aadr=16'h3000 -> adr 16'h3000; pc=16'hFFFF, radr=1 -> adr 16'h0000.
- Stall and retry: hold stall=1 for 3 cycles then rty once, then ack -> stb stays high 3 extra cycles, re-enters ADDR at same adr after rty, valid only after ack; latency 3+3+2 cycles.
- Backpressure: valid=1, ready=0 for 5 cycles with fetch=1 -> busy=1, no stb, opc stable; ready=1 with fetch=1 -> stb next cycle, valid low next cycle.
- Reset mid-operation: assert async_rst_i low while in DATA -> cyc/stb low same cycle, valid=0, after release boot fetch of RESET_ADR; late ack while in BOOT/IDLE ignored (valid stays 0).
- Simultaneous ack and rty in DATA -> data captured, no reissue, valid=1 next cycle.
